nw_ctrl_param: RTL
==================

Name: nw_ctrl_param

Overview:
- Parametrised Needleman-Wunsch sequencing controller; successor to the fixed 4-state alignment FSM.
- Adds runtime sequence lengths, internal cell-index counters (i,j), a start/done handshake, a calc/traceback data handshake and error reporting.
- Sits between the score-matrix RAM / scoring datapath and the top-level host interface. It drives the RAM enables and the cell coordinates.

Parameters:
- N_MAX, 16, maximum sequence length per axis.
- IDX_W, $clog2(N_MAX+1), width of the i, j, len_a and len_b fields.
- PATH_W, $clog2(2*N_MAX+1), width of the traceback step counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin alignment; sampled only in IDLE or DONE.
- len_a  in  IDX_W  sequence A length (rows); latched on accepted start.
- len_b  in  IDX_W  sequence B length (cols); latched on accepted start.
- calc  in  1  scoring datapath result for cell (i,j) is valid.
- tb_valid  in  1  traceback direction input is valid this cycle.
- tb_dir  in  2  traceback step: 00 diag, 01 up, 10 left, 11 illegal.
- state  out  3  current state encoding.
- en_init, en_ins, we, en_read, en_traceB  out  1 each  datapath/RAM enables.
- i  out  IDX_W  current row index.
- j  out  IDX_W  current column index.
- path_len  out  PATH_W  traceback steps taken.
- busy  out  1  high in INIT, READ, FILL and TRACEB.
- done  out  1  high in DONE.
- err  out  1  sticky error flag for the current run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; i=j=0; path_len=0; err=0; latched lengths=0; all enables, busy and done = 0.
- State encodings: IDLE=0, INIT=1, READ=2, FILL=3, TRACEB=4, DONE=5. Codes 6 and 7 recover to IDLE on the next clock.
- Outputs are decoded from registered state only (Moore). i, j and path_len are registers.
- Enables per state, in the order en_init, en_ins, we, en_read, en_traceB:
  - IDLE 00000
  - INIT 10100
  - READ 01010
  - FILL 00100
  - TRACEB 00001
  - DONE 00000
- IDLE/DONE on start=1:
  - Latch len_a and len_b; clear path_len and err; set i=j=0.
  - If either length is 0 or greater than N_MAX: go to DONE with err=1.
  - Otherwise go to INIT.
- INIT writes one boundary cell per cycle:
  - Row 0 first: (0,0) through (0,len_b).
  - Then column 0: (1,0) through (len_a,0).
  - Duration is exactly len_a+len_b+1 cycles.
  - After the cycle at (len_a,0): go to READ with i=1, j=1.
- READ: hold while calc=0, with no timeout. On calc=1, go to FILL.
- FILL: lasts exactly one cycle with we=1 for cell (i,j). Then:
  - If i==len_a and j==len_b: go to TRACEB, keeping i and j.
  - Else if j==len_b: j=1, i=i+1, go to READ.
  - Else: j=j+1, go to READ.
- TRACEB: on each cycle with tb_valid=1:
  - Boundary forcing: if i==0 the step is forced left; if j==0 it is forced up, regardless of tb_dir.
  - diag decrements both i and j; up decrements i; left decrements j. path_len increments by 1.
  - tb_dir=11 with i>0 and j>0: set err=1, go to DONE, leave i and j unchanged.
  - If i==0 and j==0 at state entry or after a step: go to DONE. No step is taken at (0,0).
- DONE: done=1 is held until an accepted start.
- start is ignored while busy.
- calc and tb_valid are ignored outside READ and TRACEB respectively.
- Reset asserted mid-run aborts immediately to the reset values. No partial done pulse is produced.
- Index arithmetic is unsigned IDX_W wide. Boundary forcing guarantees no underflow.
- Total fill-phase cycles, excluding calc wait: 2*len_a*len_b.

Decomposition:
- Package nw_pkg holds:
  - the state encoding localparams
  - the tb_dir encodings (DIR_DIAG, DIR_UP, DIR_LEFT, DIR_BAD)
  - the enable-vector constants per state
- Sub-module nw_idx_cnt holds the i/j counter pair. It provides load, row-walk, column-walk, raster-increment and traceback-decrement modes, and outputs wrap/zero flags. The FSM stays in nw_ctrl_param.

Test Plan:
- Full run, len_a=2, len_b=3, calc held high:
  - INIT lasts 6 cycles: (0,0..3) then (1,0), (2,0).
  - FILL visits (1,1), (1,2), (1,3), (2,1), (2,2), (2,3) in order, each READ/FILL pair taking 2 cycles.
  - Then TRACEB is entered at (2,3).
- calc delayed 4 cycles on cell (1,2): READ holds 4 extra cycles; we stays 0 throughout; no index change.
- Traceback from (2,3) with dirs diag, left, diag: path (1,2), (1,1), (0,0); path_len=3; done=1; err=0.
- Boundary forcing: traceback at (0,2) with tb_dir=01 -> moves to (0,1), then (0,0); DONE.
- Errors:
  - start with len_a=0 -> DONE next cycle with err=1, busy never asserted.
  - tb_dir=11 at (2,2) -> DONE, err=1, i=2, j=2.
- rst_n pulsed low during FILL, and start pulsed during READ: reset returns all outputs to 0 asynchronously, with state=IDLE. The start pulse has no effect on state, i or j.

Source files
------------

// File: rtl/nw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nw_pkg
// Brief    : Shared encodings for the Needleman-Wunsch sequencing controller.
// Revision : 1.0
// ============================================================================
package nw_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_TRACEB = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  // Bit order: {en_init, en_ins, we, en_read, en_traceB}
  localparam logic [4:0] EN_IDLE   = 5'b00000;
  localparam logic [4:0] EN_INIT   = 5'b10100;
  localparam logic [4:0] EN_READ   = 5'b01010;
  localparam logic [4:0] EN_FILL   = 5'b00100;
  localparam logic [4:0] EN_TRACEB = 5'b00001;
  localparam logic [4:0] EN_DONE   = 5'b00000;

  localparam logic [2:0] CNT_HOLD   = 3'd0;
  localparam logic [2:0] CNT_LOAD0  = 3'd1;
  localparam logic [2:0] CNT_LOAD1  = 3'd2;
  localparam logic [2:0] CNT_ROW    = 3'd3;
  localparam logic [2:0] CNT_COL    = 3'd4;
  localparam logic [2:0] CNT_RASTER = 3'd5;
  localparam logic [2:0] CNT_TB     = 3'd6;

  function automatic logic [4:0] state_enables(input logic [2:0] st);
    logic [4:0] en;
    case (st)
      ST_INIT:   en = EN_INIT;
      ST_READ:   en = EN_READ;
      ST_FILL:   en = EN_FILL;
      ST_TRACEB: en = EN_TRACEB;
      ST_DONE:   en = EN_DONE;
      default:   en = EN_IDLE;
    endcase
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nw_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module   : nw_idx_cnt
// Brief    : Row/column cell-index counter pair with walk, raster and
//            traceback-decrement modes.
// Revision : 1.0
// ============================================================================
module nw_idx_cnt
  import nw_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       i_mode,
  input  logic [IDX_W-1:0] i_len_a,
  input  logic [IDX_W-1:0] i_len_b,
  input  logic [1:0]       i_dir,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j,
  output logic             o_row_end,
  output logic             o_col_end,
  output logic             o_origin,
  output logic             o_step_bad,
  output logic             o_step_origin
);

  logic [IDX_W-1:0] r_i, r_j;
  logic [1:0]       w_dir;
  logic             w_dec_i, w_dec_j;
  logic [IDX_W-1:0] w_ti, w_tj;

  // On a boundary the step direction is forced, so the decrement never underflows.
  always_comb begin
    if (r_i == '0)      w_dir = DIR_LEFT;
    else if (r_j == '0) w_dir = DIR_UP;
    else                w_dir = i_dir;
    w_dec_i = (w_dir == DIR_DIAG) || (w_dir == DIR_UP);
    w_dec_j = (w_dir == DIR_DIAG) || (w_dir == DIR_LEFT);
    w_ti    = r_i - IDX_W'(w_dec_i);
    w_tj    = r_j - IDX_W'(w_dec_j);
  end

  assign o_step_bad    = (w_dir == DIR_BAD);
  assign o_step_origin = (w_ti == '0) && (w_tj == '0) && !o_step_bad;
  assign o_row_end     = (r_j == i_len_b);
  assign o_col_end     = (r_i == i_len_a);
  assign o_origin      = (r_i == '0) && (r_j == '0);
  assign o_i           = r_i;
  assign o_j           = r_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0;
      r_j <= '0;
    end else begin
      case (i_mode)
        CNT_LOAD0: begin
          r_i <= '0;
          r_j <= '0;
        end
        CNT_LOAD1: begin
          r_i <= IDX_W'(1);
          r_j <= IDX_W'(1);
        end
        CNT_ROW: r_j <= r_j + IDX_W'(1);
        CNT_COL: begin
          r_i <= r_i + IDX_W'(1);
          r_j <= '0;
        end
        CNT_RASTER: begin
          if (o_row_end) begin
            r_i <= r_i + IDX_W'(1);
            r_j <= IDX_W'(1);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        CNT_TB: begin
          if (!o_step_bad) begin
            r_i <= w_ti;
            r_j <= w_tj;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nw_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : nw_ctrl_param
// Brief    : Parametrised Needleman-Wunsch sequencing controller (init, fill,
//            traceback) driving score-RAM enables and cell coordinates.
// Revision : 1.0
// ============================================================================
module nw_ctrl_param
  import nw_pkg::*;
#(
  parameter int N_MAX  = 16,
  parameter int IDX_W  = $clog2(N_MAX + 1),
  parameter int PATH_W = $clog2(2 * N_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  len_a,
  input  logic [IDX_W-1:0]  len_b,
  input  logic              calc,
  input  logic              tb_valid,
  input  logic [1:0]        tb_dir,
  output logic [2:0]        state,
  output logic              en_init,
  output logic              en_ins,
  output logic              we,
  output logic              en_read,
  output logic              en_traceB,
  output logic [IDX_W-1:0]  i,
  output logic [IDX_W-1:0]  j,
  output logic [PATH_W-1:0] path_len,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [2:0]        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_len_a, r_len_b;
  logic [PATH_W-1:0] r_path_len;
  logic              r_err;
  logic [2:0]        w_cnt_mode;
  logic              w_accept, w_len_bad, w_step, w_err_set;
  logic              w_row_end, w_col_end, w_origin, w_step_bad, w_step_origin;

  nw_idx_cnt #(.IDX_W(IDX_W)) u_idx_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_mode        (w_cnt_mode),
    .i_len_a       (r_len_a),
    .i_len_b       (r_len_b),
    .i_dir         (tb_dir),
    .o_i           (i),
    .o_j           (j),
    .o_row_end     (w_row_end),
    .o_col_end     (w_col_end),
    .o_origin      (w_origin),
    .o_step_bad    (w_step_bad),
    .o_step_origin (w_step_origin)
  );

  assign w_len_bad = (len_a == '0) || (len_b == '0) ||
                     (len_a > IDX_W'(N_MAX)) || (len_b > IDX_W'(N_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_mode  = CNT_HOLD;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_cnt_mode  = CNT_LOAD0;
          w_state_nxt = w_len_bad ? ST_DONE : ST_INIT;
        end
      end
      ST_INIT: begin
        // Row 0 left to right, then column 0 downward.
        if (i == '0) begin
          w_cnt_mode = w_row_end ? CNT_COL : CNT_ROW;
        end else if (w_col_end) begin
          w_cnt_mode  = CNT_LOAD1;
          w_state_nxt = ST_READ;
        end else begin
          w_cnt_mode = CNT_COL;
        end
      end
      ST_READ: begin
        if (calc) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_row_end && w_col_end) begin
          w_state_nxt = ST_TRACEB;
        end else begin
          w_cnt_mode  = CNT_RASTER;
          w_state_nxt = ST_READ;
        end
      end
      ST_TRACEB: begin
        if (w_origin) begin
          w_state_nxt = ST_DONE;
        end else if (tb_valid) begin
          if (w_step_bad) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_step     = 1'b1;
            w_cnt_mode = CNT_TB;
            if (w_step_origin) w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len_a    <= '0;
      r_len_b    <= '0;
      r_path_len <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_len_a    <= len_a;
        r_len_b    <= len_b;
        r_path_len <= '0;
        r_err      <= w_len_bad;
      end else begin
        if (w_step)    r_path_len <= r_path_len + PATH_W'(1);
        if (w_err_set) r_err      <= 1'b1;
      end
    end
  end

  assign {en_init, en_ins, we, en_read, en_traceB} = state_enables(r_state);
  assign state    = r_state;
  assign path_len = r_path_len;
  assign err      = r_err;
  assign done     = (r_state == ST_DONE);
  assign busy     = (r_state == ST_INIT) || (r_state == ST_READ) ||
                    (r_state == ST_FILL) || (r_state == ST_TRACEB);

endmodule
`default_nettype wire
